// File: rtl/beam_sum_accumulator_pkg.sv
// rtl/beam_sum_accumulator_pkg.sv - shared defaults, width helper and FSM states for the beam summer
package beam_sum_accumulator_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ELEMENTS = 8;
  localparam int DEF_POINTS   = 1024;

  // Growth of $clog2(elements) bits makes the coherent sum overflow-free
  function automatic int acc_width(input int data_w, input int elements);
    return data_w + $clog2(elements);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/beam_sum_accumulator_if.sv
// rtl/beam_sum_accumulator_if.sv - sample input stream and beamformed point output handshake
interface beam_sum_accumulator_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 35
);
  logic [DATA_W-1:0] sample_value;
  logic              sample_good;
  logic [ACC_W-1:0]  out_sum;
  logic [15:0]       out_index;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  sample_value, sample_good, out_ready,
    output out_sum, out_index, out_valid
  );

  modport slave (
    output sample_value, sample_good, out_ready,
    input  out_sum, out_index, out_valid
  );
endinterface

// File: rtl/beam_sum_accumulator_out_reg.sv
// rtl/beam_sum_accumulator_out_reg.sv - one-entry valid/ready point holder with sticky overrun
module beam_sum_accumulator_out_reg #(
  parameter int ACC_W = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ACC_W-1:0] load_sum,
  input  logic [15:0]      load_index,
  input  logic             clr_overrun,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [15:0]      out_index,
  output logic             out_valid,
  output logic             overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
      // A word accepted this cycle frees the slot for a point completing in the same cycle
      if (load) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_sum   <= load_sum;
          out_index <= load_index;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/beam_sum_accumulator.sv
// rtl/beam_sum_accumulator.sv - sums ELEMENTS qualified samples per point, POINTS points per frame
module beam_sum_accumulator
  import beam_sum_accumulator_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ELEMENTS = DEF_ELEMENTS,
  parameter int POINTS   = DEF_POINTS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  beam_sum_accumulator_if.master  bus,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int ACC_W = acc_width(DATA_W, ELEMENTS);
  localparam int EW    = $clog2(ELEMENTS);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [EW-1:0]     elem_cnt;
  logic [15:0]       point_cnt;
  logic              complete;
  logic              last_point;
  logic              clr_overrun;

  assign acc_sum     = acc + {{(ACC_W-DATA_W){bus.sample_value[DATA_W-1]}}, bus.sample_value};
  assign complete    = (state == ACCUM) && start && bus.sample_good && (elem_cnt == EW'(ELEMENTS-1));
  assign last_point  = (point_cnt == 16'(POINTS-1));
  assign clr_overrun = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (!start) state_nxt = IDLE;
               else if (complete && last_point) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort and frame start both clear the datapath; a pending output word survives an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      elem_cnt  <= '0;
      point_cnt <= '0;
    end else if (clr_overrun || ((state == ACCUM) && !start)) begin
      acc       <= '0;
      elem_cnt  <= '0;
      point_cnt <= '0;
    end else if ((state == ACCUM) && bus.sample_good) begin
      if (complete) begin
        acc       <= '0;
        elem_cnt  <= '0;
        point_cnt <= point_cnt + 16'd1;
      end else begin
        acc      <= acc_sum;
        elem_cnt <= elem_cnt + EW'(1);
      end
    end
  end

  beam_sum_accumulator_out_reg #(.ACC_W(ACC_W)) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (complete),
    .load_sum    (acc_sum),
    .load_index  (point_cnt),
    .clr_overrun (clr_overrun),
    .out_ready   (bus.out_ready),
    .out_sum     (bus.out_sum),
    .out_index   (bus.out_index),
    .out_valid   (bus.out_valid),
    .overrun     (overrun)
  );

  assign busy = (state == ACCUM);
  assign done = (state == DONE) && !bus.out_valid;

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// tb/tb_beam_sum_accumulator.sv - directed self-checking bench for beam_sum_accumulator
module tb_beam_sum_accumulator;

  localparam int DATA_W   = 32;
  localparam int ELEMENTS = 4;
  localparam int POINTS   = 3;
  localparam int ACC_W    = 34;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic overrun;
  int   errors = 0;
  int   checks = 0;

  beam_sum_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bif ();

  beam_sum_accumulator #(.DATA_W(DATA_W), .ELEMENTS(ELEMENTS), .POINTS(POINTS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bif),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the return point is the next falling edge
  task automatic drive(input logic [DATA_W-1:0] v, input logic g);
    bif.sample_value = v;
    bif.sample_good  = g;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bif.sample_value = '0;
    bif.sample_good  = 1'b0;
    bif.out_ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bif.out_valid); end
    checks++; if (bif.out_sum !== 34'd0) begin errors++; $display("FAIL reset_sum got=%0h want=0", bif.out_sum); end
    checks++; if ({busy, done, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%03b want=000", {busy, done, overrun}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start = 1'b1;
    drive('0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%0b want=1", busy); end
    drive(32'd1, 1'b1);
    drive(32'd2, 1'b1);
    drive(32'd3, 1'b1);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0b want=0", bif.out_valid); end
    drive(32'd4, 1'b1);
    checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b want=1", bif.out_valid); end
    checks++; if (bif.out_sum !== 34'd10) begin errors++; $display("FAIL basic_sum got=%0d want=10", bif.out_sum); end
    checks++; if (bif.out_index !== 16'd0) begin errors++; $display("FAIL basic_index got=%0d want=0", bif.out_index); end
    drive('0, 1'b0);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%0b want=0", bif.out_valid); end
  endtask

  task automatic test_signed();
    drive(-32'sd5, 1'b1);
    drive(-32'sd7, 1'b1);
    drive(32'h7FFF_FFFF, 1'b1);
    drive(32'h7FFF_FFFF, 1'b1);
    checks++; if (bif.out_sum !== 34'h0_FFFF_FFF2) begin errors++; $display("FAIL signed_sum got=%0h want=0fffffff2", bif.out_sum); end
    checks++; if (bif.out_index !== 16'd1) begin errors++; $display("FAIL signed_index got=%0d want=1", bif.out_index); end
    drive('0, 1'b0);
  endtask

  task automatic test_done();
    drive(32'd100, 1'b1);
    drive(-32'sd50, 1'b1);
    drive(32'd25, 1'b1);
    drive(32'd1, 1'b1);
    checks++; if (bif.out_sum !== 34'd76 || bif.out_index !== 16'd2) begin errors++; $display("FAIL done_point got=%0d/%0d want=76/2", bif.out_sum, bif.out_index); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got=%0b want=0", done); end
    drive('0, 1'b0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_set got=%0b%0b want=10", done, busy); end
    drive(32'd9, 1'b1);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL done_ignore got=%0b want=0", bif.out_valid); end
    start = 1'b0;
    drive('0, 1'b0);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_clear got=%0b%0b want=00", done, busy); end
  endtask

  task automatic test_overrun();
    bif.out_ready = 1'b0;
    start = 1'b1;
    drive('0, 1'b0);
    for (int i = 0; i < 4; i++) drive(32'd1, 1'b1);
    for (int i = 0; i < 4; i++) drive(32'd2, 1'b1);
    checks++; if (bif.out_valid !== 1'b1 || bif.out_sum !== 34'd4) begin errors++; $display("FAIL ovr_held got=%0b/%0d want=1/4", bif.out_valid, bif.out_sum); end
    checks++; if (bif.out_index !== 16'd0) begin errors++; $display("FAIL ovr_index got=%0d want=0", bif.out_index); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%0b want=1", overrun); end
    bif.out_ready = 1'b1;
    drive('0, 1'b0);
    checks++; if (bif.out_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%0b/%0b want=0/1", bif.out_valid, overrun); end
    for (int i = 0; i < 4; i++) drive(32'd3, 1'b1);
    checks++; if (bif.out_sum !== 34'd12 || bif.out_index !== 16'd2) begin errors++; $display("FAIL ovr_last got=%0d/%0d want=12/2", bif.out_sum, bif.out_index); end
    drive('0, 1'b0);
    start = 1'b0;
    drive('0, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_idle got=%0b want=1", overrun); end
  endtask

  task automatic test_back_to_back();
    bif.out_ready = 1'b0;
    start = 1'b1;
    drive('0, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr_clear got=%0b want=0", overrun); end
    drive(32'd1, 1'b1);
    drive(32'd2, 1'b1);
    drive(32'd3, 1'b1);
    drive(32'd4, 1'b1);
    checks++; if (bif.out_valid !== 1'b1 || bif.out_sum !== 34'd10) begin errors++; $display("FAIL b2b_first got=%0b/%0d want=1/10", bif.out_valid, bif.out_sum); end
    drive(32'd5, 1'b1);
    drive(32'd6, 1'b1);
    drive(32'd7, 1'b1);
    bif.out_ready = 1'b1;
    drive(32'd8, 1'b1);
    checks++; if (bif.out_valid !== 1'b1 || bif.out_sum !== 34'd26 || bif.out_index !== 16'd1) begin errors++; $display("FAIL b2b_second got=%0b/%0d/%0d want=1/26/1", bif.out_valid, bif.out_sum, bif.out_index); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr got=%0b want=0", overrun); end
    drive('0, 1'b0);
    checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%0b want=0", bif.out_valid); end
  endtask

  task automatic test_abort();
    drive(32'd100, 1'b1);
    drive(32'd200, 1'b1);
    start = 1'b0;
    drive('0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy); end
    start = 1'b1;
    bif.out_ready = 1'b0;
    drive('0, 1'b0);
    for (int i = 0; i < 4; i++) drive(32'd1, 1'b1);
    checks++; if (bif.out_sum !== 34'd4 || bif.out_index !== 16'd0) begin errors++; $display("FAIL abort_restart got=%0d/%0d want=4/0", bif.out_sum, bif.out_index); end
    bif.sample_good = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++; if (bif.out_valid !== 1'b0 || bif.out_sum !== 34'd0 || bif.out_index !== 16'd0) begin errors++; $display("FAIL rst_mid_out got=%0b/%0d/%0d want=0/0/0", bif.out_valid, bif.out_sum, bif.out_index); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    drive('0, 1'b0);
    drive('0, 1'b0);
    drive('0, 1'b0);
    checks++; if (bif.out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_after got=%0b/%0b want=0/0", bif.out_valid, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_done();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
